// File: rtl/conway_pkg.sv
// Shared board geometry, FSM state type and cell addressing for the Game of Life engine.
package conway_pkg;
  localparam int BOARD_ROWS = 8;
  localparam int BOARD_COLS = 8;
  localparam int WORDS      = 4;
  localparam int WORD_W     = 16;
  localparam int CELLS      = BOARD_ROWS * BOARD_COLS;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_READ,
    ST_COMPUTE,
    ST_WRITE,
    ST_DONE
  } state_e;

  typedef struct packed {
    logic [1:0] word;
    logic [3:0] bit_idx;
  } cell_loc_t;

  // Row 2w sits in the high byte of word w, row 2w+1 in the low byte; column 0 is the byte MSB.
  function automatic cell_loc_t cell_loc(input logic [2:0] row, input logic [2:0] col);
    cell_loc_t loc;
    loc.word    = row[2:1];
    loc.bit_idx = {~row[0], ~col};
    return loc;
  endfunction

  // Flat index into a 64-bit board laid out as {word3, word2, word1, word0}.
  function automatic logic [5:0] cell_index(input logic [2:0] row, input logic [2:0] col);
    return cell_loc(row, col);
  endfunction
endpackage

// File: rtl/conway_step_engine_if.sv
// Selector-side port of Block_Mem: word address, read data (1-cycle latency), write data and strobe.
interface conway_step_engine_if;
  import conway_pkg::*;

  logic [1:0]        array_selector;
  logic [WORD_W-1:0] alive_out_selector;
  logic [WORD_W-1:0] alive_in_selector;
  logic              write_enb;

  modport master (
    output array_selector,
    output alive_in_selector,
    output write_enb,
    input  alive_out_selector
  );

  modport slave (
    input  array_selector,
    input  alive_in_selector,
    input  write_enb,
    output alive_out_selector
  );
endinterface

// File: rtl/conway_next_state.sv
// Combinational Game of Life rule over a 64-cell board, with live-cell count of the result.
module conway_next_state
  import conway_pkg::*;
#(
  parameter int TOROIDAL = 0
) (
  input  logic [CELLS-1:0] i_board,
  output logic [CELLS-1:0] o_board,
  output logic [6:0]       o_pop
);

  // Truncating to 3 bits turns -1 into 7 and 8 into 0, which is exactly the torus wrap.
  function automatic logic cell_at(input logic [CELLS-1:0] b, input int r, input int c);
    if (TOROIDAL == 0 && (r < 0 || r >= BOARD_ROWS || c < 0 || c >= BOARD_COLS))
      return 1'b0;
    return b[cell_index(3'(r), 3'(c))];
  endfunction

  function automatic logic [3:0] nbrs(input logic [CELLS-1:0] b, input int r, input int c);
    logic [3:0] n;
    n = '0;
    for (int dr = -1; dr <= 1; dr++) begin
      for (int dc = -1; dc <= 1; dc++) begin
        if (dr != 0 || dc != 0)
          n = n + 4'(cell_at(b, r + dr, c + dc));
      end
    end
    return n;
  endfunction

  always_comb begin
    o_board = '0;
    for (int r = 0; r < BOARD_ROWS; r++) begin
      for (int c = 0; c < BOARD_COLS; c++) begin
        o_board[cell_index(3'(r), 3'(c))] =
          (nbrs(i_board, r, c) == 4'd3) ||
          (i_board[cell_index(3'(r), 3'(c))] && nbrs(i_board, r, c) == 4'd2);
      end
    end
  end

  always_comb begin
    o_pop = '0;
    for (int i = 0; i < CELLS; i++)
      o_pop = o_pop + 7'(o_board[i]);
  end

endmodule

// File: rtl/conway_step_engine.sv
// One-generation step engine: reads the 8x8 board from Block_Mem, applies the rule, writes it back.
module conway_step_engine
  import conway_pkg::*;
#(
  parameter int TOROIDAL = 0,
  parameter int GEN_W    = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  output logic                 busy,
  output logic                 done,
  conway_step_engine_if.master mem,
  output logic [GEN_W-1:0]     gen_count,
  output logic [6:0]           pop_count
);

  state_e           r_state;
  state_e           w_state_nxt;
  logic [2:0]       r_k;
  logic [CELLS-1:0] r_cur;
  logic [CELLS-1:0] r_next;
  logic [CELLS-1:0] w_next_board;
  logic [6:0]       w_next_pop;
  logic [6:0]       r_pop;
  logic [GEN_W-1:0] r_gen;
  logic [1:0]       w_cap_word;
  logic             w_stay_seq;

  conway_next_state #(.TOROIDAL(TOROIDAL)) u_rule (
    .i_board (r_cur),
    .o_board (w_next_board),
    .o_pop   (w_next_pop)
  );

  // Read data arrives one cycle after its address, so READ slot k lands in word k-1.
  assign w_cap_word = r_k[1:0] - 2'd1;
  assign w_stay_seq = (w_state_nxt == r_state) &&
                      (r_state == ST_READ || r_state == ST_WRITE);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= ST_IDLE;
      r_k     <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_k     <= w_stay_seq ? r_k + 3'd1 : 3'd0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_cur  <= '0;
      r_next <= '0;
      r_pop  <= '0;
      r_gen  <= '0;
    end else begin
      if (r_state == ST_READ && r_k != 3'd0)
        r_cur[{w_cap_word, 4'd0} +: WORD_W] <= mem.alive_out_selector;
      if (r_state == ST_COMPUTE) begin
        r_next <= w_next_board;
        r_pop  <= w_next_pop;
      end
      if (r_state == ST_DONE)
        r_gen <= r_gen + {{(GEN_W-1){1'b0}}, 1'b1};
    end
  end

  always_comb begin
    w_state_nxt           = r_state;
    busy                  = 1'b1;
    done                  = 1'b0;
    mem.write_enb         = 1'b0;
    mem.array_selector    = '0;
    mem.alive_in_selector = '0;
    unique case (r_state)
      ST_IDLE: begin
        busy = 1'b0;
        if (start) w_state_nxt = ST_READ;
      end
      ST_READ: begin
        mem.array_selector = (r_k >= 3'd3) ? 2'd3 : r_k[1:0];
        if (r_k == 3'd4) w_state_nxt = ST_COMPUTE;
      end
      ST_COMPUTE: w_state_nxt = ST_WRITE;
      ST_WRITE: begin
        mem.write_enb         = 1'b1;
        mem.array_selector    = r_k[1:0];
        mem.alive_in_selector = r_next[{r_k[1:0], 4'd0} +: WORD_W];
        if (r_k == 3'd3) w_state_nxt = ST_DONE;
      end
      ST_DONE: begin
        done        = 1'b1;
        w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  assign gen_count = r_gen;
  assign pop_count = r_pop;

endmodule

// File: tb/tb_conway_step_engine.sv
// Bench for conway_step_engine: bounded and toroidal instances side by side on separate memory models.
module tb_conway_step_engine;
  logic clk = 1'b0;
  logic reset, start;
  always #5 clk = ~clk;

  conway_step_engine_if mif0();
  conway_step_engine_if mif1();

  logic        busy0, busy1, done0, done1;
  logic [15:0] gen0, gen1;
  logic [6:0]  pop0, pop1;

  conway_step_engine #(.TOROIDAL(0), .GEN_W(16)) u_dut0 (
    .clk(clk), .reset(reset), .start(start), .busy(busy0), .done(done0),
    .mem(mif0), .gen_count(gen0), .pop_count(pop0));

  conway_step_engine #(.TOROIDAL(1), .GEN_W(16)) u_dut1 (
    .clk(clk), .reset(reset), .start(start), .busy(busy1), .done(done1),
    .mem(mif1), .gen_count(gen1), .pop_count(pop1));

  // Block_Mem models: one-cycle read latency, controller preload port used only while idle.
  logic [15:0] mem0[4];
  logic [15:0] mem1[4];
  logic        pl_we;
  logic [1:0]  pl_addr;
  logic [15:0] pl_d0, pl_d1;

  always @(posedge clk) begin
    if (pl_we) begin
      mem0[pl_addr] <= pl_d0;
      mem1[pl_addr] <= pl_d1;
    end else begin
      if (mif0.write_enb) mem0[mif0.array_selector] <= mif0.alive_in_selector;
      if (mif1.write_enb) mem1[mif1.array_selector] <= mif1.alive_in_selector;
    end
    mif0.alive_out_selector <= mem0[mif0.array_selector];
    mif1.alive_out_selector <= mem1[mif1.array_selector];
  end

  logic        o_busy[2], o_done[2], o_we[2];
  logic [1:0]  o_sel[2];
  logic [15:0] o_wd[2], o_gen[2];
  logic [6:0]  o_pop[2];
  assign o_busy[0] = busy0;  assign o_busy[1] = busy1;
  assign o_done[0] = done0;  assign o_done[1] = done1;
  assign o_we[0]   = mif0.write_enb;          assign o_we[1]  = mif1.write_enb;
  assign o_sel[0]  = mif0.array_selector;     assign o_sel[1] = mif1.array_selector;
  assign o_wd[0]   = mif0.alive_in_selector;  assign o_wd[1]  = mif1.alive_in_selector;
  assign o_gen[0]  = gen0;   assign o_gen[1] = gen1;
  assign o_pop[0]  = pop0;   assign o_pop[1] = pop1;

  int          errors = 0;
  int          checks = 0;
  int          exp_gen = 0;
  logic [63:0] sh[2];

  function automatic logic [63:0] pack4(input logic [15:0] w0, input logic [15:0] w1,
                                        input logic [15:0] w2, input logic [15:0] w3);
    return {w3, w2, w1, w0};
  endfunction

  function automatic logic [63:0] mem_board(input int d);
    if (d == 0) return {mem0[3], mem0[2], mem0[1], mem0[0]};
    return {mem1[3], mem1[2], mem1[1], mem1[0]};
  endfunction

  // Reference: plain 8x8 grid, neighbours counted directly from the rules of Life.
  function automatic void life_model(input logic [63:0] wi, input bit tor,
                                     output logic [63:0] wo, output int pop);
    int b[8][8];
    int nb, rr, cc, pos;
    for (int r = 0; r < 8; r++)
      for (int c = 0; c < 8; c++) begin
        pos = (r / 2) * 16 + ((r % 2 == 0) ? 15 : 7) - c;
        b[r][c] = wi[pos] ? 1 : 0;
      end
    wo  = '0;
    pop = 0;
    for (int r = 0; r < 8; r++)
      for (int c = 0; c < 8; c++) begin
        nb = 0;
        for (int dr = -1; dr <= 1; dr++)
          for (int dc = -1; dc <= 1; dc++) begin
            if (dr == 0 && dc == 0) continue;
            rr = r + dr;
            cc = c + dc;
            if (tor) nb += b[(rr + 8) % 8][(cc + 8) % 8];
            else if (rr >= 0 && rr < 8 && cc >= 0 && cc < 8) nb += b[rr][cc];
          end
        if ((b[r][c] == 1 && (nb == 2 || nb == 3)) || (b[r][c] == 0 && nb == 3)) begin
          pos = (r / 2) * 16 + ((r % 2 == 0) ? 15 : 7) - c;
          wo[pos] = 1'b1;
          pop++;
        end
      end
  endfunction

  task automatic apply_reset();
    @(negedge clk);
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset   = 1'b0;
    exp_gen = 0;
  endtask

  task automatic preload(input logic [63:0] b0, input logic [63:0] b1);
    for (int w = 0; w < 4; w++) begin
      @(negedge clk);
      pl_we   = 1'b1;
      pl_addr = 2'(w);
      pl_d0   = b0[w*16 +: 16];
      pl_d1   = b1[w*16 +: 16];
    end
    @(negedge clk);
    pl_we = 1'b0;
    sh[0] = b0;
    sh[1] = b1;
  endtask

  task automatic run_step();
    logic [63:0] ex[2];
    int          ep[2];
    logic [1:0]  ea;
    life_model(sh[0], 1'b0, ex[0], ep[0]);
    life_model(sh[1], 1'b1, ex[1], ep[1]);
    @(negedge clk);
    start = 1'b1;
    for (int i = 1; i <= 12; i++) begin
      @(negedge clk);
      start = 1'b0;
      for (int d = 0; d < 2; d++) begin
        checks++;
        if (o_busy[d] !== (i <= 11)) begin
          errors++;
          $display("FAIL step_busy dut%0d N+%0d: got %b want %b", d, i, o_busy[d], (i <= 11));
        end
        checks++;
        if (o_done[d] !== (i == 11)) begin
          errors++;
          $display("FAIL step_done dut%0d N+%0d: got %b want %b", d, i, o_done[d], (i == 11));
        end
        checks++;
        if (o_we[d] !== (i >= 7 && i <= 10)) begin
          errors++;
          $display("FAIL step_we dut%0d N+%0d: got %b want %b", d, i, o_we[d], (i >= 7 && i <= 10));
        end
        if (i <= 5 || (i >= 7 && i <= 10)) begin
          ea = (i <= 5) ? ((i - 1 > 3) ? 2'd3 : 2'(i - 1)) : 2'(i - 7);
          checks++;
          if (o_sel[d] !== ea) begin
            errors++;
            $display("FAIL step_addr dut%0d N+%0d: got %0d want %0d", d, i, o_sel[d], ea);
          end
        end
        if (i >= 7 && i <= 10) begin
          checks++;
          if (o_wd[d] !== ex[d][(i-7)*16 +: 16]) begin
            errors++;
            $display("FAIL step_wdata dut%0d N+%0d: got %h want %h", d, i, o_wd[d], ex[d][(i-7)*16 +: 16]);
          end
        end
      end
    end
    exp_gen++;
    for (int d = 0; d < 2; d++) begin
      checks++;
      if (o_gen[d] !== 16'(exp_gen)) begin
        errors++;
        $display("FAIL gen_count dut%0d: got %0d want %0d", d, o_gen[d], exp_gen);
      end
      checks++;
      if (o_pop[d] !== 7'(ep[d])) begin
        errors++;
        $display("FAIL pop_count dut%0d: got %0d want %0d", d, o_pop[d], ep[d]);
      end
      checks++;
      if (mem_board(d) !== ex[d]) begin
        errors++;
        $display("FAIL mem_board dut%0d: got %h want %h", d, mem_board(d), ex[d]);
      end
    end
    sh[0] = ex[0];
    sh[1] = ex[1];
  endtask

  task automatic test_reset();
    apply_reset();
    for (int d = 0; d < 2; d++) begin
      checks++;
      if ({o_busy[d], o_done[d], o_we[d], o_sel[d], o_wd[d], o_gen[d], o_pop[d]} !== '0) begin
        errors++;
        $display("FAIL reset_state dut%0d: busy=%b done=%b we=%b sel=%0d wd=%h gen=%0d pop=%0d want all 0",
                 d, o_busy[d], o_done[d], o_we[d], o_sel[d], o_wd[d], o_gen[d], o_pop[d]);
      end
    end
  endtask

  task automatic test_dying();
    apply_reset();
    preload(pack4(16'h0600, 0, 0, 0), pack4(16'h0600, 0, 0, 0));
    run_step();
    for (int d = 0; d < 2; d++) begin
      checks++;
      if (mem_board(d) !== 64'h0 || o_pop[d] !== 7'd0 || o_gen[d] !== 16'd1) begin
        errors++;
        $display("FAIL dying dut%0d: board=%h pop=%0d gen=%0d want 0/0/1", d, mem_board(d), o_pop[d], o_gen[d]);
      end
    end
  endtask

  task automatic test_still_life();
    logic [63:0] blk;
    blk = pack4(16'h1818, 0, 0, 0);
    apply_reset();
    preload(blk, blk);
    for (int s = 0; s < 4; s++) begin
      run_step();
      for (int d = 0; d < 2; d++) begin
        checks++;
        if (mem_board(d) !== blk || o_pop[d] !== 7'd4) begin
          errors++;
          $display("FAIL still_life dut%0d step%0d: board=%h pop=%0d want %h/4", d, s, mem_board(d), o_pop[d], blk);
        end
      end
    end
    for (int d = 0; d < 2; d++) begin
      checks++;
      if (o_gen[d] !== 16'd4) begin
        errors++;
        $display("FAIL still_life_gen dut%0d: got %0d want 4", d, o_gen[d]);
      end
    end
  endtask

  task automatic test_blinker();
    logic [63:0] want[2];
    want[0] = pack4(16'h0008, 16'h0808, 0, 0);
    want[1] = pack4(16'h0000, 16'h1C00, 0, 0);
    apply_reset();
    preload(want[1], want[1]);
    for (int s = 0; s < 2; s++) begin
      run_step();
      for (int d = 0; d < 2; d++) begin
        checks++;
        if (mem_board(d) !== want[s] || o_pop[d] !== 7'd3) begin
          errors++;
          $display("FAIL blinker dut%0d step%0d: board=%h pop=%0d want %h/3", d, s, mem_board(d), o_pop[d], want[s]);
        end
      end
    end
  endtask

  task automatic test_edge_policy();
    logic [63:0] want[2];
    logic [6:0]  wpop[2];
    want[0] = pack4(16'h4040, 0, 0, 0);
    want[1] = pack4(16'h4040, 0, 0, 16'h0040);
    wpop[0] = 7'd2;
    wpop[1] = 7'd3;
    apply_reset();
    preload(pack4(16'hE000, 0, 0, 0), pack4(16'hE000, 0, 0, 0));
    run_step();
    for (int d = 0; d < 2; d++) begin
      checks++;
      if (mem_board(d) !== want[d] || o_pop[d] !== wpop[d]) begin
        errors++;
        $display("FAIL edge_policy dut%0d: board=%h pop=%0d want %h/%0d", d, mem_board(d), o_pop[d], want[d], wpop[d]);
      end
    end
  endtask

  task automatic test_random();
    for (int t = 0; t < 6; t++) begin
      preload({$urandom, $urandom} & {$urandom, $urandom}, {$urandom, $urandom});
      run_step();
      run_step();
    end
  endtask

  task automatic test_back_to_back();
    logic [63:0] e1[2], e2[2];
    int          p1[2], p2[2];
    logic        want_busy;
    apply_reset();
    preload({$urandom, $urandom}, {$urandom, $urandom});
    for (int d = 0; d < 2; d++) begin
      life_model(sh[d], d == 1, e1[d], p1[d]);
      life_model(e1[d], d == 1, e2[d], p2[d]);
    end
    @(negedge clk);
    start = 1'b1;
    for (int i = 1; i <= 28; i++) begin
      @(negedge clk);
      if (i == 20) start = 1'b0;
      want_busy = (i % 12 != 0) && (i <= 23);
      for (int d = 0; d < 2; d++) begin
        checks++;
        if (o_busy[d] !== want_busy || o_done[d] !== (i == 11 || i == 23)) begin
          errors++;
          $display("FAIL held_start dut%0d N+%0d: busy=%b done=%b want %b/%b",
                   d, i, o_busy[d], o_done[d], want_busy, (i == 11 || i == 23));
        end
      end
    end
    for (int d = 0; d < 2; d++) begin
      checks++;
      if (o_gen[d] !== 16'd2 || o_pop[d] !== 7'(p2[d]) || mem_board(d) !== e2[d]) begin
        errors++;
        $display("FAIL held_start_result dut%0d: gen=%0d pop=%0d board=%h want 2/%0d/%h",
                 d, o_gen[d], o_pop[d], mem_board(d), p2[d], e2[d]);
      end
    end
    sh[0]   = e2[0];
    sh[1]   = e2[1];
    exp_gen = 2;
  endtask

  task automatic test_reset_mid_step();
    logic [63:0] ex[2];
    int          ep[2];
    apply_reset();
    preload(pack4(16'h1C00, 16'h0600, 16'h0018, 16'h3000), {$urandom, $urandom});
    for (int d = 0; d < 2; d++) life_model(sh[d], d == 1, ex[d], ep[d]);
    @(negedge clk);
    start = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      @(negedge clk);
      start = 1'b0;
    end
    reset = 1'b1;
    @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      checks++;
      if (o_busy[d] !== 1'b0 || o_we[d] !== 1'b0 || o_done[d] !== 1'b0 ||
          o_gen[d] !== 16'd0 || o_pop[d] !== 7'd0) begin
        errors++;
        $display("FAIL mid_reset dut%0d: busy=%b we=%b done=%b gen=%0d pop=%0d want all 0",
                 d, o_busy[d], o_we[d], o_done[d], o_gen[d], o_pop[d]);
      end
    end
    reset   = 1'b0;
    exp_gen = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      for (int d = 0; d < 2; d++) begin
        checks++;
        if (o_done[d] !== 1'b0 || o_busy[d] !== 1'b0) begin
          errors++;
          $display("FAIL mid_reset_quiet dut%0d: busy=%b done=%b want 0/0", d, o_busy[d], o_done[d]);
        end
      end
    end
    // Words 0 and 1 were written before the reset edge; 2 and 3 keep the old generation.
    for (int d = 0; d < 2; d++) sh[d] = {sh[d][63:32], ex[d][31:0]};
    run_step();
  endtask

  initial begin
    reset   = 1'b1;
    start   = 1'b0;
    pl_we   = 1'b0;
    pl_addr = '0;
    pl_d0   = '0;
    pl_d1   = '0;
    test_reset();
    test_dying();
    test_still_life();
    test_blinker();
    test_edge_policy();
    test_random();
    test_back_to_back();
    test_reset_mid_step();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
